mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 66 ++++++
 rtl/mem_access_unit_lane_align.sv | 57 +++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory access unit: memory port bundles,
// access sizes, controller states and alignment helpers.
package mem_access_unit_pkg;

  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned DataWidth    = 32;

  typedef logic [DataWidth-1:0] Register;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } mem_en_e;

  typedef struct packed {
    logic [MemAddrWidth-1:0] addr;
    Register                 val;
  } M_data;

  typedef struct packed {
    mem_en_e read;
    mem_en_e write;
    M_data   data;
  } M_input;

  typedef struct packed {
    Register val;
  } M_output;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    STORE  = 3'd4,
    RESP   = 3'd5
  } mau_state_e;

  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] addr_lo);
    return ((sz == SZ_HALF) && addr_lo[0]) || ((sz == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

  // Clear the low address bits a half/word access cannot legally use.
  function automatic logic [MemAddrWidth-1:0] force_align(input mem_size_e sz,
                                                          input logic [MemAddrWidth-1:0] addr);
    logic [MemAddrWidth-1:0] a;
    a = addr;
    case (sz)
      SZ_HALF: a[0]   = 1'b0;
      SZ_WORD: a[1:0] = 2'b00;
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic [MemAddrWidth-1:0] word_addr(input logic [MemAddrWidth-1:0] addr);
    return {addr[MemAddrWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane logic: extracts/extends a load lane from a memory word
// and merges store data into the addressed lane of an old word.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  Register    word_i,
  input  logic [1:0] addr_lo_i,
  input  mem_size_e  size_i,
  input  logic       signed_i,
  input  Register    wdata_i,
  output Register    ld_val_c_o,
  output Register    st_word_c_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Load path: select lane, then sign- or zero-extend.
  always_comb begin
    byte_v = word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: ;
    endcase
    half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    ld_val_c_o = word_i;
    case (size_i)
      SZ_BYTE: ld_val_c_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: ld_val_c_o = {{16{signed_i & half_v[15]}}, half_v};
      default: ;
    endcase
  end

  // Store path: replace only the addressed lane of the old word.
  always_comb begin
    st_word_c_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd0:    st_word_c_o[7:0]   = wdata_i[7:0];
          2'd1:    st_word_c_o[15:8]  = wdata_i[7:0];
          2'd2:    st_word_c_o[23:16] = wdata_i[7:0];
          default: st_word_c_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) st_word_c_o[31:16] = wdata_i[15:0];
        else              st_word_c_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_c_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory: one request at a
// time, sub-word stores via read-modify-write, one response pulse per request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  mem_size_e               req_size,
  input  logic                    req_signed,
  input  logic [MemAddrWidth-1:0] req_addr,
  input  Register                 req_wdata,
  output logic                    resp_valid,
  output Register                 resp_rdata,
  output logic                    resp_err,
  output M_input                  mem_in,
  input  M_output                 mem_out
);

  mau_state_e              state_q, state_d;
  logic [MemAddrWidth-1:0] addr_q, addr_d;
  mem_size_e               size_q, size_d;
  logic                    signed_q, signed_d;
  Register                 wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  Register                 resp_rdata_q, resp_rdata_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [MemAddrWidth-1:0] maddr_q, maddr_d;
  Register                 mval_q, mval_d;

  logic [MemAddrWidth-1:0] acc_addr;
  Register                 ld_val;
  Register                 st_word;

  assign acc_addr = CHECK_ALIGN ? req_addr : force_align(req_size, req_addr);

  mem_access_unit_lane_align u_lane_align (
    .word_i      (mem_out.val),
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .ld_val_c_o  (ld_val),
    .st_word_c_o (st_word)
  );

  // Memory strobes are set one state ahead so they are registered in the access state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    maddr_d      = '0;
    mval_d       = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = acc_addr;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (CHECK_ALIGN && is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = LOAD;
            rd_en_d = 1'b1;
            maddr_d = word_addr(acc_addr);
          end else if ((req_size == SZ_BYTE) || (req_size == SZ_HALF)) begin
            state_d = RMW_RD;
            rd_en_d = 1'b1;
            maddr_d = word_addr(acc_addr);
          end else begin
            state_d = STORE;
            wr_en_d = 1'b1;
            maddr_d = word_addr(acc_addr);
            mval_d  = req_wdata;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_val;
      end
      RMW_RD: begin
        state_d = RMW_WR;
        wr_en_d = 1'b1;
        maddr_d = word_addr(addr_q);
        mval_d  = st_word;
      end
      RMW_WR, STORE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      maddr_q      <= '0;
      mval_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      maddr_q      <= maddr_d;
      mval_q       <= mval_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // Write strobe is masked by reset so an interrupted RMW never lands in memory.
  always_comb begin
    mem_in.read      = rd_en_q ? ENABLE : DISABLE;
    mem_in.write     = (wr_en_q && !rst) ? ENABLE : DISABLE;
    mem_in.data.addr = maddr_q;
    mem_in.data.val  = mval_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one instance with alignment checking and one
// that forces alignment, each on its own behavioural memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk;
  logic rst;
  logic mem_init;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  mem_size_e   req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  M_input      mem_in     [2];
  M_output     mem_out    [2];

  logic [31:0] tb_mem  [2][64];
  logic [7:0]  ref_mem [2][256];

  int          rd_cnt [2];
  int          wr_cnt [2];
  int          resp_cnt [2];
  int          both_cnt;
  logic [31:0] rd_addr [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_val  [2];

  int n_checks;
  int n_pass;

  mem_access_unit #(.CHECK_ALIGN(1'b1)) u_dut_chk (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_in(mem_in[0]), .mem_out(mem_out[0])
  );

  mem_access_unit #(.CHECK_ALIGN(1'b0)) u_dut_frc (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_in(mem_in[1]), .mem_out(mem_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // Memory M: combinational read while read is enabled, write on posedge.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_out[k].val = (mem_in[k].read == ENABLE) ? tb_mem[k][mem_in[k].data.addr[7:2]]
                                                  : 32'hDEADBEEF;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) tb_mem[k][i] <= init_word(i);
      end else if (mem_in[k].write == ENABLE) begin
        tb_mem[k][mem_in[k].data.addr[7:2]] <= mem_in[k].data.val;
      end
      if (mem_in[k].read == ENABLE) begin
        rd_cnt[k]  <= rd_cnt[k] + 1;
        rd_addr[k] <= mem_in[k].data.addr;
      end
      if (mem_in[k].write == ENABLE) begin
        wr_cnt[k]  <= wr_cnt[k] + 1;
        wr_addr[k] <= mem_in[k].data.addr;
        wr_val[k]  <= mem_in[k].data.val;
      end
      if (resp_valid[k]) resp_cnt[k] <= resp_cnt[k] + 1;
      if ((mem_in[k].read == ENABLE) && (mem_in[k].write == ENABLE)) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Byte-addressed reference memory.
  function automatic logic [31:0] ref_load(input int k, input logic [31:0] a, input int n,
                                           input logic sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[k][8'(a + 32'(i))]) << (8 * i);
    if (sgn && (n < 4) && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input int k, input logic [31:0] a, input int n, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = wd >> (8 * i);
      ref_mem[k][8'(a + 32'(i))] = t[7:0];
    end
  endtask

  task automatic run_req(input int k, input logic we, input mem_size_e sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    int          n, lat, rd0, wr0, exp_lat, exp_rds, exp_wrs;
    logic        mis, exp_err;
    logic [31:0] ea, exp_rd, exp_wv;
    n   = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    mis = ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a[1:0] != 2'b00));
    ea  = a & ~(32'(n) - 32'd1);
    exp_rd = 32'd0; exp_wv = 32'd0; exp_err = 1'b0;
    if ((k == 0) && mis) begin
      exp_err = 1'b1; exp_lat = 1; exp_rds = 0; exp_wrs = 0;
    end else if (!we) begin
      exp_rd = ref_load(k, ea, n, sgn); exp_lat = 2; exp_rds = 1; exp_wrs = 0;
    end else begin
      ref_store(k, ea, n, wd);
      exp_wv  = ref_load(k, ea & ~32'd3, 4, 1'b0);
      exp_lat = (n == 4) ? 2 : 3;
      exp_rds = (n == 4) ? 0 : 1;
      exp_wrs = 1;
    end

    chk("ready_idle", 32'(req_ready[k]), 32'd1);
    rd0 = rd_cnt[k];
    wr0 = wr_cnt[k];
    req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = sz;
    req_signed[k] = sgn; req_addr[k] = a; req_wdata[k] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[k]  = 1'b0;
    req_we[k]     = 1'($urandom_range(0, 1));
    req_size[k]   = mem_size_e'($urandom_range(0, 2));
    req_signed[k] = 1'($urandom_range(0, 1));
    req_addr[k]   = $urandom;
    req_wdata[k]  = $urandom;
    lat = 1;
    while (!resp_valid[k] && (lat < 8)) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", 32'(resp_valid[k]), 32'd1);
    rd = resp_rdata[k];
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", rd, exp_rd);
    chk("err", 32'(resp_err[k]), 32'(exp_err));
    chk("read_cycles", 32'(rd_cnt[k] - rd0), 32'(exp_rds));
    chk("write_cycles", 32'(wr_cnt[k] - wr0), 32'(exp_wrs));
    if (exp_rds == 1) chk("rd_addr", rd_addr[k], ea & ~32'd3);
    if (exp_wrs == 1) begin
      chk("wr_addr", wr_addr[k], ea & ~32'd3);
      chk("wr_val", wr_val[k], exp_wv);
    end
    @(negedge clk);
    chk("one_pulse", 32'(resp_valid[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, w, t;
    logic [5:0]  b2b_rdy, b2b_rsp;
    int          wr0, rsp0;
    n_checks = 0; n_pass = 0;
    for (int k = 0; k < 2; k++) begin
      rd_cnt[k] = 0; wr_cnt[k] = 0; resp_cnt[k] = 0;
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = SZ_WORD;
      req_signed[k] = 1'b0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      for (int i = 0; i < 64; i++) begin
        w = init_word(i);
        for (int b = 0; b < 4; b++) begin
          t = w >> (8 * b);
          ref_mem[k][8'(4 * i + b)] = t[7:0];
        end
      end
    end
    both_cnt = 0;
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_resp_err", 32'(resp_err[k]), 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'd0);
      chk("rst_enables", 32'({mem_in[k].read, mem_in[k].write}), 32'd0);
      chk("rst_maddr", mem_in[k].data.addr, 32'd0);
      chk("rst_mval", mem_in[k].data.val, 32'd0);
    end
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    // Directed loads on the preloaded word 0x8899AABB.
    run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd); chk("wl_10", rd, 32'h8899AABB);
    run_req(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, rd); chk("lb_13", rd, 32'hFFFFFF88);
    run_req(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, rd); chk("lbu_13", rd, 32'h00000088);
    run_req(0, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0, rd); chk("lh_12", rd, 32'hFFFF8899);
    run_req(0, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'd0, rd); chk("lhu_10", rd, 32'h0000AABB);
    run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'd0, rd); chk("mis_chk", rd, 32'd0);
    run_req(1, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'd0, rd); chk("mis_frc", rd, 32'h8899AABB);

    // Back-to-back with req_valid held high.
    rsp0 = resp_cnt[0];
    b2b_rdy = 6'b100100;
    b2b_rsp = 6'b010010;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = SZ_WORD;
    req_signed[0] = 1'b0; req_addr[0] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", i), 32'(req_ready[0]), 32'(b2b_rdy[i]));
      chk($sformatf("b2b_resp%0d", i), 32'(resp_valid[0]), 32'(b2b_rsp[i]));
      if (b2b_rsp[i]) chk("b2b_rdata", resp_rdata[0], 32'h8899AABB);
      if (i == 4) req_valid[0] = 1'b0;
    end
    chk("b2b_count", 32'(resp_cnt[0] - rsp0), 32'd2);

    // Byte store by read-modify-write, then read back.
    run_req(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000CC, rd);
    chk("sb_wr_val", wr_val[0], 32'h8899CCBB);
    run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd); chk("wl_after_sb", rd, 32'h8899CCBB);

    // Reset during the write phase of a half store.
    wr0 = wr_cnt[0]; rsp0 = resp_cnt[0];
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = SZ_HALF;
    req_addr[0] = 32'h10; req_wdata[0] = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_writes", 32'(wr_cnt[0] - wr0), 32'd0);
    chk("rst_mid_resp", 32'(resp_cnt[0] - rsp0), 32'd0);
    run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd); chk("wl_after_rst", rd, 32'h8899CCBB);

    // Random traffic against the byte-level reference model.
    for (int j = 0; j < 60; j++) begin
      run_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              mem_size_e'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom, rd);
    end

    chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
